mips_exec_mem_unit: RTL and testbench

//  Control decode, 32-bit ALU and word-addressed data memory of the single-cycle MIPS core.

---
 rtl/mips_pkg.sv | 39 +++
 rtl/alu_32bit.sv | 32 +++
 rtl/mips_exec_mem_unit.sv | 127 ++++++++++++
 tb/tb_mips_exec_mem_unit.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared encodings for the single-cycle MIPS execute/memory slice: opcodes,
// R-type function codes, ALU operation codes and next-PC select values.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_SRL = 6'h02;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_NOR = 6'h27;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef enum logic [3:0] {
        ALU_AND = 4'b0000,
        ALU_OR  = 4'b0001,
        ALU_ADD = 4'b0010,
        ALU_SUB = 4'b0110,
        ALU_SLT = 4'b0111,
        ALU_SLL = 4'b1000,
        ALU_SRL = 4'b1001,
        ALU_NOR = 4'b1100
    } alu_op_e;

    localparam logic [1:0] JSEL_PC4    = 2'b00;
    localparam logic [1:0] JSEL_BRANCH = 2'b01;
    localparam logic [1:0] JSEL_JUMP   = 2'b10;

endpackage

// File: rtl/alu_32bit.sv
// Purely combinational 32-bit ALU with zero flag. Shifts act on shift_src
// (the rt register) by shamt, independent of the operand-B mux.
module alu_32bit
    import mips_pkg::*;
(
    input  logic [3:0]  alu_op,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    input  logic [31:0] shift_src,
    input  logic [4:0]  shamt,
    output logic [31:0] result,
    output logic        zero
);

    always_comb begin
        result = '0;
        case (alu_op)
            ALU_AND: result = op_a & op_b;
            ALU_OR:  result = op_a | op_b;
            ALU_ADD: result = op_a + op_b;
            ALU_SUB: result = op_a - op_b;
            ALU_SLT: result = ($signed(op_a) < $signed(op_b)) ? 32'd1 : 32'd0;
            ALU_NOR: result = ~(op_a | op_b);
            ALU_SLL: result = shift_src << shamt;
            ALU_SRL: result = shift_src >> shamt;
            default: result = '0;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/mips_exec_mem_unit.sv
// Control decode, ALU and word-addressed data memory of the single-cycle core.
// All outputs are combinational in the inputs and the current memory contents.
module mips_exec_mem_unit
    import mips_pkg::*;
#(
    parameter int DEPTH = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  opcode,
    input  logic [5:0]  func,
    input  logic [4:0]  shamt,
    input  logic [31:0] reg_a,
    input  logic [31:0] reg_b,
    input  logic [31:0] imm,
    output logic [3:0]  alu_control,
    output logic        reg_write,
    output logic        mem_read,
    output logic        mem_write,
    output logic        reg_dst,
    output logic        branch,
    output logic        jump,
    output logic        alu_src,
    output logic [1:0]  jump_sel,
    output logic [31:0] alu_result,
    output logic        zero,
    output logic [31:0] read_data
);

    localparam int AW = $clog2(DEPTH);

    alu_op_e      dec_alu_op;
    logic         dec_reg_write;
    logic         dec_mem_write;
    logic [31:0]  op_b;
    logic [AW-1:0] mem_idx;
    logic [31:0]  mem [DEPTH];

    always_comb begin
        dec_alu_op    = ALU_ADD;
        dec_reg_write = 1'b0;
        dec_mem_write = 1'b0;
        mem_read      = 1'b0;
        reg_dst       = 1'b0;
        branch        = 1'b0;
        jump          = 1'b0;
        alu_src       = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                // Strobes only assert for a recognised func; otherwise the op is a no-op.
                reg_dst       = 1'b1;
                dec_reg_write = 1'b1;
                case (func)
                    FN_ADD:  dec_alu_op = ALU_ADD;
                    FN_SUB:  dec_alu_op = ALU_SUB;
                    FN_AND:  dec_alu_op = ALU_AND;
                    FN_OR:   dec_alu_op = ALU_OR;
                    FN_NOR:  dec_alu_op = ALU_NOR;
                    FN_SLT:  dec_alu_op = ALU_SLT;
                    FN_SLL:  dec_alu_op = ALU_SLL;
                    FN_SRL:  dec_alu_op = ALU_SRL;
                    default: begin
                        reg_dst       = 1'b0;
                        dec_reg_write = 1'b0;
                    end
                endcase
            end
            OP_LW: begin
                alu_src       = 1'b1;
                mem_read      = 1'b1;
                dec_reg_write = 1'b1;
            end
            OP_SW: begin
                alu_src       = 1'b1;
                dec_mem_write = 1'b1;
            end
            OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: begin
                alu_src       = 1'b1;
                dec_reg_write = 1'b1;
                case (opcode)
                    OP_ANDI: dec_alu_op = ALU_AND;
                    OP_ORI:  dec_alu_op = ALU_OR;
                    OP_SLTI: dec_alu_op = ALU_SLT;
                    default: dec_alu_op = ALU_ADD;
                endcase
            end
            OP_BEQ: begin
                branch     = 1'b1;
                dec_alu_op = ALU_SUB;
            end
            OP_J: jump = 1'b1;
            default: ;
        endcase
    end

    assign alu_control = dec_alu_op;
    assign reg_write   = dec_reg_write & reset;
    assign mem_write   = dec_mem_write & reset;
    assign jump_sel    = jump            ? JSEL_JUMP   :
                         (branch & zero) ? JSEL_BRANCH : JSEL_PC4;

    assign op_b = alu_src ? imm : reg_b;

    alu_32bit u_alu (
        .alu_op    (alu_control),
        .op_a      (reg_a),
        .op_b      (op_b),
        .shift_src (reg_b),
        .shamt     (shamt),
        .result    (alu_result),
        .zero      (zero)
    );

    // Byte address, word granularity; upper bits beyond the array simply alias.
    assign mem_idx = alu_result[AW+1:2];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (dec_mem_write) begin
            mem[mem_idx] <= reg_b;
        end
    end

    assign read_data = mem_read ? mem[mem_idx] : '0;

endmodule

// File: tb/tb_mips_exec_mem_unit.sv
// Directed self-checking bench for mips_exec_mem_unit with hand-computed expectations.
module tb_mips_exec_mem_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  opcode;
    logic [5:0]  func;
    logic [4:0]  shamt;
    logic [31:0] reg_a;
    logic [31:0] reg_b;
    logic [31:0] imm;
    logic [3:0]  alu_control;
    logic        reg_write, mem_read, mem_write, reg_dst, branch, jump, alu_src;
    logic [1:0]  jump_sel;
    logic [31:0] alu_result;
    logic        zero;
    logic [31:0] read_data;

    int checks = 0;
    int errors = 0;

    // {reg_write, mem_read, mem_write, reg_dst, branch, jump, alu_src}
    logic [6:0] strobes;
    assign strobes = {reg_write, mem_read, mem_write, reg_dst, branch, jump, alu_src};

    always #5 clk = ~clk;

    mips_exec_mem_unit #(.DEPTH(64)) dut (
        .clk         (clk),
        .reset       (reset),
        .opcode      (opcode),
        .func        (func),
        .shamt       (shamt),
        .reg_a       (reg_a),
        .reg_b       (reg_b),
        .imm         (imm),
        .alu_control (alu_control),
        .reg_write   (reg_write),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .reg_dst     (reg_dst),
        .branch      (branch),
        .jump        (jump),
        .alu_src     (alu_src),
        .jump_sel    (jump_sel),
        .alu_result  (alu_result),
        .zero        (zero),
        .read_data   (read_data)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    // Each call passes one rising edge, so a held sw is written exactly once.
    task automatic apply(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] sh,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] im);
        @(negedge clk);
        opcode = op; func = fn; shamt = sh;
        reg_a = a; reg_b = b; imm = im;
        #1;
    endtask

    initial begin
        reset  = 1'b0;
        opcode = 6'h00; func = 6'h20; shamt = 5'd0;
        reg_a  = '0; reg_b = '0; imm = '0;

        // Reset held: a store must not be issued and memory reads back cleared.
        apply(6'h2B, 6'h00, 5'd0, 32'h10, 32'hDEADBEEF, 32'h4);
        chk("rst_sw_mem_write", {31'b0, mem_write}, 32'h0);
        chk("rst_sw_alu_src",   {31'b0, alu_src},   32'h1);
        apply(6'h23, 6'h00, 5'd0, 32'h10, 32'h0, 32'h4);
        chk("rst_lw_read",      read_data, 32'h0);
        chk("rst_lw_reg_write", {31'b0, reg_write}, 32'h0);
        chk("rst_lw_mem_read",  {31'b0, mem_read},  32'h1);

        @(negedge clk);
        reset = 1'b1;

        apply(6'h08, 6'h00, 5'd0, 32'd5, 32'h0, 32'hFFFFFFFD);
        chk("addi_ctrl",    {28'b0, alu_control}, 32'h2);
        chk("addi_result",  alu_result, 32'h2);
        chk("addi_strobes", {25'b0, strobes}, 32'b1000001);

        apply(6'h00, 6'h22, 5'd0, 32'd3, 32'd7, 32'h0);
        chk("sub_ctrl",    {28'b0, alu_control}, 32'h6);
        chk("sub_result",  alu_result, 32'hFFFFFFFC);
        chk("sub_zero",    {31'b0, zero}, 32'h0);
        chk("sub_strobes", {25'b0, strobes}, 32'b1001000);

        apply(6'h00, 6'h2A, 5'd0, 32'd3, 32'd7, 32'h0);
        chk("slt_result", alu_result, 32'h1);
        apply(6'h00, 6'h22, 5'd0, 32'd9, 32'd9, 32'h0);
        chk("sub_eq_zero", {31'b0, zero}, 32'h1);
        apply(6'h0A, 6'h00, 5'd0, 32'hFFFFFFFE, 32'h0, 32'h1);
        chk("slti_signed", alu_result, 32'h1);
        apply(6'h00, 6'h27, 5'd0, 32'hF0F0F0F0, 32'h0F0F0000, 32'h0);
        chk("nor_result", alu_result, 32'h0000_0F0F);
        apply(6'h0C, 6'h00, 5'd0, 32'h1234_5678, 32'h0, 32'h0000_FF00);
        chk("andi_result", alu_result, 32'h0000_5600);
        apply(6'h0D, 6'h00, 5'd0, 32'h1234_0000, 32'h0, 32'h0000_00FF);
        chk("ori_result", alu_result, 32'h1234_00FF);
        apply(6'h00, 6'h00, 5'd4, 32'h0, 32'h1, 32'h0);
        chk("sll_result", alu_result, 32'h10);
        chk("sll_ctrl", {28'b0, alu_control}, 32'h8);
        apply(6'h00, 6'h02, 5'd4, 32'h0, 32'h8000_0000, 32'h0);
        chk("srl_result", alu_result, 32'h0800_0000);

        apply(6'h2B, 6'h00, 5'd0, 32'h10, 32'hDEADBEEF, 32'h4);
        chk("sw_addr",     alu_result, 32'h14);
        chk("sw_strobes",  {25'b0, strobes}, 32'b0010001);
        chk("sw_no_read",  read_data, 32'h0);
        apply(6'h23, 6'h00, 5'd0, 32'h10, 32'h0, 32'h4);
        chk("lw_word5",    read_data, 32'hDEADBEEF);
        chk("lw_strobes",  {25'b0, strobes}, 32'b1100001);
        apply(6'h23, 6'h00, 5'd0, 32'h17, 32'h0, 32'h0);
        chk("lw_low_bits", read_data, 32'hDEADBEEF);
        apply(6'h23, 6'h00, 5'd0, 32'h10, 32'h0, 32'h0);
        chk("lw_word4",    read_data, 32'h0);
        apply(6'h23, 6'h00, 5'd0, 32'h18, 32'h0, 32'h0);
        chk("lw_word6",    read_data, 32'h0);

        // 4*DEPTH = 0x100 must land on word 0.
        apply(6'h2B, 6'h00, 5'd0, 32'h100, 32'hCAFEF00D, 32'h0);
        apply(6'h23, 6'h00, 5'd0, 32'h0, 32'h0, 32'h0);
        chk("alias_word0", read_data, 32'hCAFEF00D);

        apply(6'h04, 6'h00, 5'd0, 32'd9, 32'd9, 32'h0);
        chk("beq_eq_branch", {31'b0, branch}, 32'h1);
        chk("beq_eq_jsel",   {30'b0, jump_sel}, 32'h1);
        apply(6'h04, 6'h00, 5'd0, 32'd9, 32'd8, 32'h0);
        chk("beq_ne_jsel",   {30'b0, jump_sel}, 32'h0);
        apply(6'h02, 6'h00, 5'd0, 32'h0, 32'h0, 32'h0);
        chk("j_jump", {31'b0, jump}, 32'h1);
        chk("j_jsel", {30'b0, jump_sel}, 32'h2);

        apply(6'h3F, 6'h00, 5'd0, 32'h5, 32'h5, 32'h0);
        chk("bad_op_strobes", {25'b0, strobes}, 32'h0);
        chk("bad_op_ctrl",    {28'b0, alu_control}, 32'h2);
        chk("bad_op_jsel",    {30'b0, jump_sel}, 32'h0);
        apply(6'h00, 6'h3F, 5'd0, 32'h5, 32'h5, 32'h0);
        chk("bad_fn_strobes", {25'b0, strobes}, 32'h0);
        chk("bad_fn_ctrl",    {28'b0, alu_control}, 32'h2);

        // Asynchronous clear mid-cycle, observed before any clock edge.
        apply(6'h23, 6'h00, 5'd0, 32'h10, 32'h0, 32'h4);
        chk("pre_rst_lw", read_data, 32'hDEADBEEF);
        #2 reset = 1'b0;
        #1;
        chk("async_clear", read_data, 32'h0);
        chk("async_reg_write", {31'b0, reg_write}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
